// File: rtl/rst_seq.sv
// Staged reset sequencer: waits for a stable clock-wizard lock, then releases
// bram_rst and, STAGE_GAP cycles later, core_rst; counts lock losses after release.
module rst_seq #(
   parameter int unsigned LOCK_STABLE = 1024,
   parameter int unsigned STAGE_GAP   = 16,
   parameter int unsigned LOSS_W      = 8
) (
   input  logic              clkin,
   input  logic              rst,
   input  logic              locked,
   input  logic              restart_req,
   output logic              bram_rst,
   output logic              core_rst,
   output logic              ready,
   output logic              restart_ack,
   output logic [LOSS_W-1:0] loss_cnt
);

   localparam int unsigned      CNT_W       = 16;
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE - 1);
   localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(STAGE_GAP - 1);

   typedef enum logic [2:0] {
      S_HOLD      = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_STABLE    = 3'd2,
      S_REL_BRAM  = 3'd3,
      S_RUN       = 3'd4
   } state_t;

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_sync1;
   logic               r_sync2;
   logic               w_locked_s;
   logic [LOSS_W-1:0]  w_loss_next;

   assign w_locked_s  = r_sync2;
   assign w_loss_next = (&loss_cnt) ? loss_cnt : loss_cnt + LOSS_W'(1);

   // Two-flop synchronizer for the asynchronous lock status
   always_ff @(posedge clkin or posedge rst) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= locked;
         r_sync2 <= r_sync1;
      end
   end

   // Sequencer; outputs are updated on the same edge as the state they belong to
   always_ff @(posedge clkin or posedge rst) begin
      if (rst) begin
         r_state     <= S_HOLD;
         r_cnt       <= '0;
         bram_rst    <= 1'b1;
         core_rst    <= 1'b1;
         ready       <= 1'b0;
         restart_ack <= 1'b0;
         loss_cnt    <= '0;
      end else begin
         restart_ack <= 1'b0;
         case (r_state)
            S_HOLD: begin
               bram_rst <= 1'b1;
               core_rst <= 1'b1;
               ready    <= 1'b0;
               r_cnt    <= '0;
               r_state  <= S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
               r_cnt <= '0;
               if (w_locked_s) r_state <= S_STABLE;
            end
            S_STABLE: begin
               if (!w_locked_s) begin
                  r_cnt   <= '0;
                  r_state <= S_WAIT_LOCK;
               end else if (r_cnt == STABLE_LAST) begin
                  r_cnt    <= '0;
                  bram_rst <= 1'b0;
                  r_state  <= S_REL_BRAM;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_REL_BRAM: begin
               if (!w_locked_s) begin
                  bram_rst <= 1'b1;
                  core_rst <= 1'b1;
                  ready    <= 1'b0;
                  r_cnt    <= '0;
                  loss_cnt <= w_loss_next;
                  r_state  <= S_HOLD;
               end else if (r_cnt == GAP_LAST) begin
                  r_cnt    <= '0;
                  core_rst <= 1'b0;
                  ready    <= 1'b1;
                  r_state  <= S_RUN;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_RUN: begin
               // Lock loss and restart may coincide: count the loss and still ack
               if (!w_locked_s || restart_req) begin
                  bram_rst    <= 1'b1;
                  core_rst    <= 1'b1;
                  ready       <= 1'b0;
                  r_cnt       <= '0;
                  restart_ack <= restart_req;
                  r_state     <= S_HOLD;
                  if (!w_locked_s) loss_cnt <= w_loss_next;
               end
            end
            default: begin
               bram_rst <= 1'b1;
               core_rst <= 1'b1;
               ready    <= 1'b0;
               r_cnt    <= '0;
               r_state  <= S_HOLD;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rst_seq.sv
// Scoreboard bench for rst_seq: stimulus queues expected output changes with
// their cycle numbers, a negedge monitor pops one entry per observed change.
module tb_rst_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       locked;
   logic       restart_req;
   logic       bram_rst;
   logic       core_rst;
   logic       ready;
   logic       restart_ack;
   logic [1:0] loss_cnt;
   logic [5:0] outs;

   int cyc   = 0;
   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      int         cyc;
      logic [5:0] val;
      string      name;
   } ev_t;

   ev_t        exp_q[$];
   logic [5:0] prev = 6'b110000;
   logic [5:0] cur;
   ev_t        got;

   rst_seq #(.LOCK_STABLE(8), .STAGE_GAP(4), .LOSS_W(2)) dut (
      .clkin       (clk),
      .rst         (rst),
      .locked      (locked),
      .restart_req (restart_req),
      .bram_rst    (bram_rst),
      .core_rst    (core_rst),
      .ready       (ready),
      .restart_ack (restart_ack),
      .loss_cnt    (loss_cnt)
   );

   assign outs = {bram_rst, core_rst, ready, restart_ack, loss_cnt};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk_val(input string name, input logic [5:0] act, input logic [5:0] exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got {bram,core,ready,ack,loss}=%b, want %b", name, act, exp_v);
      end
   endtask

   task automatic expect_ev(input string name, input int c, input bit b, input bit co,
                            input bit r, input bit a, input int l);
      ev_t e;
      e.cyc  = c;
      e.val  = {b, co, r, a, 2'(l)};
      e.name = name;
      exp_q.push_back(e);
   endtask

   task automatic wait_to(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: every change of the output vector must match the next queued event
   always @(negedge clk) begin
      cur = outs;
      if (cur !== prev) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_change: cyc=%0d got=%b (no event queued)", cyc, cur);
         end else begin
            got = exp_q.pop_front();
            if (got.cyc != cyc || got.val !== cur) begin
               n_bad++;
               $display("FAIL %s: got cyc=%0d val=%b, want cyc=%0d val=%b",
                        got.name, cyc, cur, got.cyc, got.val);
            end
         end
         prev = cur;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int p;
      int q;
      rst         = 1'b0;
      locked      = 1'b0;
      restart_req = 1'b0;
      #1 rst = 1'b1;
      #1 chk_val("reset_state", outs, 6'b110000);
      wait_to(3);

      // Clean power-up with lock present from release
      p = cyc; rst = 1'b0; locked = 1'b1;
      expect_ev("t1_bram_rel", p + 11, 0, 1, 0, 0, 0);
      expect_ev("t1_core_rel", p + 15, 0, 0, 1, 0, 0);
      wait_to(p + 20);

      // Lock loss in RUN, then relock
      p = cyc; locked = 1'b0;
      expect_ev("t2_loss_hold", p + 3, 1, 1, 0, 0, 1);
      wait_to(p + 6); locked = 1'b1;
      expect_ev("t2_bram_rel", p + 17, 0, 1, 0, 0, 1);
      expect_ev("t2_core_rel", p + 21, 0, 0, 1, 0, 1);
      wait_to(p + 26);

      // Single-cycle restart in RUN
      p = cyc; restart_req = 1'b1;
      expect_ev("t3_ack", p + 1, 1, 1, 0, 1, 1);
      expect_ev("t3_ack_end", p + 2, 1, 1, 0, 0, 1);
      expect_ev("t3_bram_rel", p + 11, 0, 1, 0, 0, 1);
      expect_ev("t3_core_rel", p + 15, 0, 0, 1, 0, 1);
      wait_to(p + 1); restart_req = 1'b0;
      wait_to(p + 20);

      // Restart, then a 1-cycle lock glitch mid-STABLE and an ignored restart in STABLE
      p = cyc; restart_req = 1'b1;
      expect_ev("t4_ack", p + 1, 1, 1, 0, 1, 1);
      expect_ev("t4_ack_end", p + 2, 1, 1, 0, 0, 1);
      expect_ev("t4_bram_rel", p + 17, 0, 1, 0, 0, 1);
      expect_ev("t4_core_rel", p + 21, 0, 0, 1, 0, 1);
      wait_to(p + 1); restart_req = 1'b0;
      wait_to(p + 5); locked = 1'b0;
      wait_to(p + 6); locked = 1'b1;
      wait_to(p + 12); restart_req = 1'b1;
      wait_to(p + 13); restart_req = 1'b0;
      wait_to(p + 26);

      // Restart coinciding with lock loss in RUN
      p = cyc; locked = 1'b0;
      wait_to(p + 2); restart_req = 1'b1;
      expect_ev("t5_loss_ack", p + 3, 1, 1, 0, 1, 2);
      expect_ev("t5_ack_end", p + 4, 1, 1, 0, 0, 2);
      wait_to(p + 3); restart_req = 1'b0;
      wait_to(p + 6); locked = 1'b1;
      expect_ev("t5_bram_rel", p + 17, 0, 1, 0, 0, 2);
      expect_ev("t5_core_rel", p + 21, 0, 0, 1, 0, 2);
      wait_to(p + 26);

      // Further losses in RUN saturate the 2-bit counter at 3
      for (int k = 3; k <= 4; k++) begin
         p = cyc; locked = 1'b0;
         expect_ev("t6_loss_hold", p + 3, 1, 1, 0, 0, 3);
         wait_to(p + 6); locked = 1'b1;
         expect_ev("t6_bram_rel", p + 17, 0, 1, 0, 0, 3);
         expect_ev("t6_core_rel", p + 21, 0, 0, 1, 0, 3);
         wait_to(p + 26);
      end

      // Lock loss during REL_BRAM
      p = cyc; locked = 1'b0;
      expect_ev("t7_loss_hold", p + 3, 1, 1, 0, 0, 3);
      wait_to(p + 6); locked = 1'b1;
      q = p + 6;
      expect_ev("t7_bram_rel", q + 11, 0, 1, 0, 0, 3);
      wait_to(q + 11); locked = 1'b0;
      expect_ev("t7_relbram_loss", q + 14, 1, 1, 0, 0, 3);
      wait_to(q + 17);

      // Asynchronous reset while in REL_BRAM clears everything immediately
      q = cyc; locked = 1'b1;
      expect_ev("t8_bram_rel", q + 11, 0, 1, 0, 0, 3);
      wait_to(q + 12);
      #2 rst = 1'b1;
      expect_ev("t8_async_rst", q + 12, 1, 1, 0, 0, 0);
      #1 chk_val("async_reset_no_edge", outs, 6'b110000);
      wait_to(q + 15);
      p = cyc; rst = 1'b0;
      expect_ev("t8_bram_rel2", p + 11, 0, 1, 0, 0, 0);
      expect_ev("t8_core_rel2", p + 15, 0, 0, 1, 0, 0);
      wait_to(p + 20);

      // restart_req held high: one ack per RUN entry
      p = cyc; restart_req = 1'b1;
      expect_ev("t9_ack1", p + 1, 1, 1, 0, 1, 0);
      expect_ev("t9_ack1_end", p + 2, 1, 1, 0, 0, 0);
      expect_ev("t9_bram_rel", p + 11, 0, 1, 0, 0, 0);
      expect_ev("t9_core_rel", p + 15, 0, 0, 1, 0, 0);
      expect_ev("t9_ack2", p + 16, 1, 1, 0, 1, 0);
      expect_ev("t9_ack2_end", p + 17, 1, 1, 0, 0, 0);
      wait_to(p + 17); restart_req = 1'b0;
      expect_ev("t9_bram_rel2", p + 26, 0, 1, 0, 0, 0);
      expect_ev("t9_core_rel2", p + 30, 0, 0, 1, 0, 0);
      wait_to(p + 35);

      chk_val("final_state", outs, 6'b001000);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL missing_events: got %0d events never observed, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
